brq_fp_wb_arbiter: RTL and testbench
====================================

Name: brq_fp_wb_arbiter

Overview:
Writer side of the FP register file write port. Accepts FP results from two producers, the FPU and the LSU (FLW/FLD loads), over valid/ready. Arbitrates them round-robin onto the single registered write port (waddr/wdata/we). Keeps a per-register pending-write scoreboard that the issue stage uses for RAW/WAW hazard checks on FP operands.

Parameters:
DataWidth, 32, width of write data and of both producer result buses.
NumRegs, 32, number of FP registers tracked; address width is clog2(NumRegs), 5 at default.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
issue_valid_i  in  1  an FP-destination instruction issues this cycle
issue_rd_i  in  5  destination register of the issuing instruction
busy_o  out  NumRegs  per-register pending-write flag, registered
waw_err_o  out  1  sticky: an issue targeted an already-busy register
flush_i  in  1  pipeline flush, clears scoreboard
fpu_valid_i  in  1  FPU result valid
fpu_ready_o  out  1  FPU result accepted this cycle
fpu_rd_i  in  5  FPU destination register
fpu_wdata_i  in  DataWidth  FPU result
lsu_valid_i  in  1  LSU load result valid
lsu_ready_o  out  1  LSU result accepted this cycle
lsu_rd_i  in  5  LSU destination register
lsu_wdata_i  in  DataWidth  LSU result
waddr_a_o  out  5  register file write address, registered
wdata_a_o  out  DataWidth  register file write data, registered
we_a_o  out  1  register file write enable, registered, one-cycle pulse per write

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - we_a_o=0, waddr_a_o=0, wdata_a_o=0.
  - busy_o=0, waw_err_o=0.
  - Priority pointer resets to LSU.
  - Reset mid-transfer discards the in-flight write, which never reaches the register file.
- Handshake and arbitration:
  - A transfer occurs when valid_i and ready_o are both 1 in the same cycle.
  - ready_o is combinational from the valid inputs, the pointer and flush_i. A producer must hold valid/rd/wdata stable until it sees ready.
  - Only one valid: that source gets ready=1.
  - Both valid: the pointer's source wins, and the pointer then flips to the other source. The pointer changes only on contention.
  - Neither valid: both readys are 0 (never-ready-when-idle is allowed).
  - The losing source holds valid. It is guaranteed the grant on the next contended cycle, so starvation is bounded to 1 cycle.
- Write port:
  - Exactly one register stage: a transfer in cycle N gives we_a_o=1 with the winner's rd/wdata in cycle N+1.
  - Throughput is 1 write per cycle.
  - No transfer in a cycle gives we_a_o=0 next cycle. waddr/wdata hold their last value.
- Scoreboard:
  - issue_valid_i sets busy[issue_rd_i] at the next edge.
  - A cycle with we_a_o=1 clears busy[waddr_a_o] at the next edge.
  - Set and clear on the same register in the same cycle: set wins, busy stays 1 (new owner).
  - Issue to a register already busy, with no clear that cycle: busy stays 1 and waw_err_o goes to 1 and stays 1 until reset. Upstream stalls on busy, so this is a checker flag.
  - A write to a non-busy register is performed normally and the scoreboard is unchanged.
- Flush:
  - flush_i=1 forces both readys to 0 that cycle and clears all busy bits at the next edge.
  - An issue in the same cycle as flush is ignored.
  - A write already in the output stage still commits (we_a_o stays 1). Its clear is redundant.
  - waw_err_o is not cleared by flush.
  - The priority pointer is unchanged by flush.
- Width rules:
  - Register indices are 5 bits. issue_rd_i values at or above NumRegs are ignored by the scoreboard.
  - No reset value is required on the register file side; this block only drives it.

Test Plan:
- Reset, then FPU-only transfer rd=5, data=0x41A00000 in cycle 3 -> we_a_o=1, waddr=5, wdata=0x41A00000 in cycle 4 only; lsu_ready_o=0 throughout.
- Both valid for 4 cycles (LSU rd=1, FPU rd=2), pointer=LSU after reset -> grant order LSU,FPU,LSU,FPU; writes rd 1,2,1,2 on consecutive cycles.
- issue rd=7 in cycle 1 -> busy_o[7]=1 from cycle 2. FPU writes rd=7, we_a_o in cycle 6 -> busy_o[7]=0 from cycle 7.
- Same-cycle issue rd=7 and we_a_o with waddr=7 -> busy_o[7] stays 1, waw_err_o stays 0.
- issue rd=3 twice with no intervening write -> waw_err_o=1 and sticky until rst_i; busy_o[3]=1.
- flush_i with busy=0x0000_00F0 and a write to rd=4 in the output stage -> that write commits, busy_o=0 next cycle, both readys 0 during the flush cycle.

Source files
------------

// File: rtl/brq_fp_wb_arbiter.sv
// FP register file write-port arbiter.
// Two producers (FPU results and LSU loads) compete for one registered write
// port. Arbitration is round-robin on contention only. A per-register
// scoreboard tracks outstanding writes for the issue stage's hazard checks.
module brq_fp_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRegs   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  output logic [NumRegs-1:0]   busy_o,
  output logic                 waw_err_o,
  input  logic                 flush_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_rd_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o
);

  // Priority pointer encoding: which source wins the next contended cycle.
  localparam logic [0:0] PtrFpu = 1'b0;
  localparam logic [0:0] PtrLsu = 1'b1;

  logic [0:0]         ptr_q;
  logic               contend;
  logic               fpu_gnt;
  logic               lsu_gnt;
  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] set_vec;
  logic [NumRegs-1:0] clr_vec;
  logic               waw_hit;
  logic               waw_q;

  // Grant: a lone requester always wins; on contention the pointer decides.
  // Flush blocks all transfers so nothing new enters the write stage.
  always_comb begin
    contend = fpu_valid_i & lsu_valid_i;
    lsu_gnt = ~flush_i & lsu_valid_i & (~fpu_valid_i | (ptr_q == PtrLsu));
    fpu_gnt = ~flush_i & fpu_valid_i & (~lsu_valid_i | (ptr_q == PtrFpu));
  end

  assign fpu_ready_o = fpu_gnt;
  assign lsu_ready_o = lsu_gnt;

  // Pointer flips only when a contended cycle actually produced a transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PtrLsu;
    end else if (contend && !flush_i) begin
      ptr_q <= ~ptr_q;
    end
  end

  // Single output register stage; address/data hold when no write occurs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
    end else begin
      we_a_o <= fpu_gnt | lsu_gnt;
      if (lsu_gnt) begin
        waddr_a_o <= lsu_rd_i;
        wdata_a_o <= lsu_wdata_i;
      end else if (fpu_gnt) begin
        waddr_a_o <= fpu_rd_i;
        wdata_a_o <= fpu_wdata_i;
      end
    end
  end

  // Per-register set/clear decode. Indices at or above NumRegs match no bit
  // and are therefore ignored. An issue during flush is dropped.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NumRegs; i++) begin
      set_vec[i] = issue_valid_i & ~flush_i & (issue_rd_i == 5'(i));
      clr_vec[i] = we_a_o & (waddr_a_o == 5'(i));
    end
    waw_hit = |(set_vec & busy_q & ~clr_vec);
  end

  // Scoreboard update: set beats clear on the same register (new owner).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      if (flush_i) begin
        busy_q <= '0;
      end else begin
        busy_q <= (busy_q & ~clr_vec) | set_vec;
      end
      if (waw_hit) begin
        waw_q <= 1'b1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign waw_err_o = waw_q;

endmodule

// File: tb/tb_brq_fp_wb_arbiter.sv
// Directed bench for brq_fp_wb_arbiter: a table of per-cycle vectors with
// hand-computed results, followed by hand-written flush/WAW/reset sequences.
module tb_brq_fp_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] busy_o;
  logic        waw_err_o;
  logic        flush_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [4:0]  fpu_rd_i;
  logic [31:0] fpu_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_wdata_i;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_a_o;

  int n_checks = 0;
  int n_fail   = 0;

  brq_fp_wb_arbiter #(.DataWidth(32), .NumRegs(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .busy_o        (busy_o),
    .waw_err_o     (waw_err_o),
    .flush_i       (flush_i),
    .fpu_valid_i   (fpu_valid_i),
    .fpu_ready_o   (fpu_ready_o),
    .fpu_rd_i      (fpu_rd_i),
    .fpu_wdata_i   (fpu_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .waddr_a_o     (waddr_a_o),
    .wdata_a_o     (wdata_a_o),
    .we_a_o        (we_a_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fwd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        e_fr;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
    logic        e_waw;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [4:0] ird, input logic fl,
                     input logic fv, input logic [4:0] frd, input logic [31:0] fwd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                     input logic e_fr, input logic e_lr, input logic e_we,
                     input logic [4:0] e_wa, input logic [31:0] e_wd,
                     input logic [31:0] e_busy, input logic e_waw);
    vec_t v;
    v.iv = iv;  v.ird = ird; v.fl = fl;
    v.fv = fv;  v.frd = frd; v.fwd = fwd;
    v.lv = lv;  v.lrd = lrd; v.lwd = lwd;
    v.e_fr = e_fr; v.e_lr = e_lr; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy; v.e_waw = e_waw;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_rd_i = '0; flush_i = 1'b0;
    fpu_valid_i = 1'b0; fpu_rd_i = '0; fpu_wdata_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_wdata_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [31:0] D5 = 32'h41A0_0000;
  localparam logic [31:0] DL = 32'h1111_1111;
  localparam logic [31:0] DF = 32'h2222_2222;
  localparam logic [31:0] D7 = 32'h0707_0707;
  localparam logic [31:0] DA = 32'hAAAA_5555;
  localparam logic [31:0] DB = 32'hB0B0_B0B0;
  localparam logic [31:0] DC = 32'hC0C0_C0C0;
  localparam logic [31:0] DD = 32'hD0D0_D0D0;
  localparam logic [31:0] DE = 32'hE0E0_E0E0;
  localparam logic [31:0] DG = 32'hF0F0_F0F0;

  initial begin
    // iv ird fl | fv frd fwd | lv lrd lwd | fr lr | we wa wd | busy waw
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,0,0,     32'h0,0);   // idle after reset
    add(0,0,0, 1,5,D5,    0,0,0,      1,0, 1,5,D5,    32'h0,0);   // FPU only
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,5,D5,    32'h0,0);   // pulse ends, hold
    add(0,0,0, 1,2,DF,    1,1,DL,     0,1, 1,1,DL,    32'h0,0);   // contention: LSU
    add(0,0,0, 1,2,DF,    1,1,DL,     1,0, 1,2,DF,    32'h0,0);   // then FPU
    add(0,0,0, 1,2,DF,    1,1,DL,     0,1, 1,1,DL,    32'h0,0);
    add(0,0,0, 1,2,DF,    1,1,DL,     1,0, 1,2,DF,    32'h0,0);
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,2,DF,    32'h0,0);
    add(1,7,0, 0,0,0,     0,0,0,      0,0, 0,2,DF,    32'h80,0);  // issue rd7
    add(0,0,0, 1,7,D7,    0,0,0,      1,0, 1,7,D7,    32'h80,0);  // write rd7
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,7,D7,    32'h0,0);   // cleared
    add(1,7,0, 0,0,0,     0,0,0,      0,0, 0,7,D7,    32'h80,0);
    add(0,0,0, 1,7,D7,    0,0,0,      1,0, 1,7,D7,    32'h80,0);
    add(1,7,0, 0,0,0,     0,0,0,      0,0, 0,7,D7,    32'h80,0);  // set wins over clear
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,7,D7,    32'h80,0);
    add(0,0,0, 1,7,D7,    0,0,0,      1,0, 1,7,D7,    32'h80,0);
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,7,D7,    32'h0,0);
    add(0,0,0, 0,0,0,     1,9,DA,     0,1, 1,9,DA,    32'h0,0);   // LSU only
    add(0,0,0, 1,11,DC,   1,10,DB,    0,1, 1,10,DB,   32'h0,0);   // ptr LSU wins
    add(0,0,0, 1,12,DD,   0,0,0,      1,0, 1,12,DD,   32'h0,0);   // no flip
    add(0,0,0, 1,14,DG,   1,13,DE,    1,0, 1,14,DG,   32'h0,0);   // ptr FPU wins
    add(0,0,0, 0,0,0,     0,0,0,      0,0, 0,14,DG,   32'h0,0);

    idle();
    rst_i = 1'b1;
    step();
    step();
    check("rst_we",    32'(we_a_o),    32'h0);
    check("rst_waddr", 32'(waddr_a_o), 32'h0);
    check("rst_wdata", wdata_a_o,      32'h0);
    check("rst_busy",  busy_o,         32'h0);
    check("rst_waw",   32'(waw_err_o), 32'h0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      issue_valid_i = vecs[i].iv; issue_rd_i = vecs[i].ird; flush_i = vecs[i].fl;
      fpu_valid_i = vecs[i].fv; fpu_rd_i = vecs[i].frd; fpu_wdata_i = vecs[i].fwd;
      lsu_valid_i = vecs[i].lv; lsu_rd_i = vecs[i].lrd; lsu_wdata_i = vecs[i].lwd;
      #1;
      check($sformatf("v%0d_fpu_ready", i), 32'(fpu_ready_o), 32'(vecs[i].e_fr));
      check($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready_o), 32'(vecs[i].e_lr));
      step();
      check($sformatf("v%0d_we", i),    32'(we_a_o),    32'(vecs[i].e_we));
      check($sformatf("v%0d_waddr", i), 32'(waddr_a_o), 32'(vecs[i].e_wa));
      check($sformatf("v%0d_wdata", i), wdata_a_o,      vecs[i].e_wd);
      check($sformatf("v%0d_busy", i),  busy_o,         vecs[i].e_busy);
      check($sformatf("v%0d_waw", i),   32'(waw_err_o), 32'(vecs[i].e_waw));
    end

    // Double issue to rd3 with no write in between: sticky WAW flag.
    idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd3;
    step();
    check("waw_first_busy", busy_o,         32'h08);
    check("waw_first_flag", 32'(waw_err_o), 32'h0);
    step();
    check("waw_second_busy", busy_o,         32'h08);
    check("waw_second_flag", 32'(waw_err_o), 32'h1);
    idle();
    step();
    step();
    check("waw_sticky", 32'(waw_err_o), 32'h1);
    flush_i = 1'b1;
    step();
    check("waw_flush_busy", busy_o,         32'h0);
    check("waw_flush_keep", 32'(waw_err_o), 32'h1);

    // Build busy=0xF0 with a write to rd4 in the output stage, then flush.
    idle(); issue_valid_i = 1'b1;
    issue_rd_i = 5'd4; step();
    issue_rd_i = 5'd5; step();
    issue_rd_i = 5'd6; step();
    issue_rd_i = 5'd7;
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd4; fpu_wdata_i = 32'h4444_4444;
    #1;
    check("fl_pre_fpu_ready", 32'(fpu_ready_o), 32'h1);
    step();
    check("fl_pre_busy",  busy_o,         32'hF0);
    check("fl_pre_we",    32'(we_a_o),    32'h1);
    check("fl_pre_waddr", 32'(waddr_a_o), 32'h4);
    flush_i = 1'b1; issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd8; fpu_wdata_i = 32'h8888_8888;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_wdata_i = 32'h9999_9999;
    #1;
    check("fl_fpu_ready",   32'(fpu_ready_o), 32'h0);
    check("fl_lsu_ready",   32'(lsu_ready_o), 32'h0);
    check("fl_commit_we",   32'(we_a_o),      32'h1);
    check("fl_commit_addr", 32'(waddr_a_o),   32'h4);
    check("fl_commit_data", wdata_a_o,        32'h4444_4444);
    step();
    check("fl_post_busy", busy_o,         32'h0);
    check("fl_post_we",   32'(we_a_o),    32'h0);
    check("fl_post_waw",  32'(waw_err_o), 32'h1);
    flush_i = 1'b0; issue_valid_i = 1'b0;
    #1;
    check("fl_ptr_lsu_ready", 32'(lsu_ready_o), 32'h1);
    check("fl_ptr_fpu_ready", 32'(fpu_ready_o), 32'h0);
    step();
    check("fl_ptr_waddr", 32'(waddr_a_o), 32'h9);

    // Reset with contention pending; pointer was left at FPU and must return to LSU.
    rst_i = 1'b1;
    step();
    check("rst2_we",    32'(we_a_o),    32'h0);
    check("rst2_waddr", 32'(waddr_a_o), 32'h0);
    check("rst2_wdata", wdata_a_o,      32'h0);
    check("rst2_busy",  busy_o,         32'h0);
    check("rst2_waw",   32'(waw_err_o), 32'h0);
    rst_i = 1'b0;
    #1;
    check("rst2_ptr_lsu_ready", 32'(lsu_ready_o), 32'h1);
    step();
    check("rst2_ptr_waddr", 32'(waddr_a_o), 32'h9);

    // Reset in the cycle of a transfer: the write is discarded.
    idle(); fpu_valid_i = 1'b1; fpu_rd_i = 5'd6; fpu_wdata_i = 32'h6666_6666;
    rst_i = 1'b1;
    step();
    check("rstx_we",    32'(we_a_o),    32'h0);
    check("rstx_waddr", 32'(waddr_a_o), 32'h0);
    rst_i = 1'b0; idle();
    step();
    check("rstx_we_after", 32'(we_a_o), 32'h0);
    check("rstx_wdata",    wdata_a_o,   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
